uart_fifo: RTL and testbench

Parametrised successor UART peripheral: serial transmitter plus receiver behind a memory-mapped 8-bit register interface, with independent TX and RX FIFOs of configurable depth, occupancy counters, sticky error flags, flush control and a synchronous reset. It sits on the same device bus as the existing peripherals and wraps the library `serial_tx`/`serial_rx` cores unchanged.

---
 rtl/uart_fifo_pkg.sv | 30 +++
 rtl/serial_rx.sv | 48 ++++
 rtl/serial_tx.sv | 37 +++
 rtl/uart_fifo_sync_fifo.sv | 46 ++++
 rtl/uart_fifo.sv | 136 +++++++++++++
 tb/tb_uart_fifo.sv | 280 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared register map, STATUS/CTRL bit positions and TX FSM encodings
// for the buffered UART peripheral.
package uart_fifo_pkg;

    localparam logic [3:0] ADDR_TX_RDY = 4'd0;
    localparam logic [3:0] ADDR_TX_DAT = 4'd1;
    localparam logic [3:0] ADDR_RX_RDY = 4'd2;
    localparam logic [3:0] ADDR_RX_DAT = 4'd3;
    localparam logic [3:0] ADDR_TX_CNT = 4'd4;
    localparam logic [3:0] ADDR_RX_CNT = 4'd5;
    localparam logic [3:0] ADDR_STATUS = 4'd6;
    localparam logic [3:0] ADDR_CTRL   = 4'd7;

    localparam int ST_RX_OVERRUN  = 0;
    localparam int ST_TX_OVERFLOW = 1;
    localparam int ST_TX_ACTIVE   = 2;
    localparam int ST_RX_FULL     = 3;
    localparam int ST_TX_EMPTY    = 4;

    localparam int CTRL_FLUSH_RX = 0;
    localparam int CTRL_FLUSH_TX = 1;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_LOAD      = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/serial_rx.sv
// Library 8N1 serial receiver; pulses o_wr for one cycle per good frame.
// No reset: synchroniser stores the inverted line so power-up reads idle.
module serial_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rx,
    output logic       o_wr,
    output logic [7:0] o_data
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    logic          meta_n, sync_n, line, busy;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [7:0]    shreg;

    assign line   = ~sync_n;
    assign o_data = shreg;

    always_ff @(posedge i_clk) begin
        meta_n <= ~i_rx;
        sync_n <= meta_n;
        o_wr   <= 1'b0;
        if (!busy) begin
            if (!line) begin
                busy <= 1'b1;
                cnt  <= CW'(CLKS_PER_BIT / 2 - 1);
                idx  <= 4'd0;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end else begin
            cnt <= CW'(CLKS_PER_BIT - 1);
            idx <= idx + 4'd1;
            // idx 0 re-checks the start bit, 9 is the stop bit
            if (idx == 4'd0) begin
                if (line) busy <= 1'b0;
            end else if (idx == 4'd9) begin
                busy <= 1'b0;
                o_wr <= line;
            end else begin
                shreg <= {line, shreg[7:1]};
            end
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Library 8N1 serial transmitter. It has no reset; the frame register
// is kept inverted so an all-zero power-up state idles the line high.
module serial_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    logic [9:0]    sh_n;
    logic [3:0]    left;
    logic [CW-1:0] cnt;

    assign o_busy = (left != 4'd0);
    assign o_tx   = o_busy ? ~sh_n[0] : 1'b1;

    always_ff @(posedge i_clk) begin
        if (!o_busy) begin
            if (i_wr) begin
                sh_n <= ~{1'b1, i_data, 1'b0};
                left <= 4'd10;
                cnt  <= '0;
            end
        end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt  <= '0;
            sh_n <= {1'b0, sh_n[9:1]};
            left <= left - 4'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_fifo_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; flush beats push/pop,
// and a pop frees room for a same-cycle push when full.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);
    localparam int CW = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign o_empty = (o_count == '0);
    assign o_full  = o_count[DEPTH_LOG2];
    assign o_data  = mem[rd_ptr];
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            o_count <= o_count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_fifo.sv
// Buffered UART: register-mapped TX/RX FIFOs around serial_tx/serial_rx.
// Define UART_LOOPBACK_EN to feed the receiver from o_tx (self-test builds).
module uart_fifo
    import uart_fifo_pkg::*;
#(
    parameter int CLK_FREQ      = 48_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_tx,
    input  logic       i_en,
    input  logic       i_wr,
    input  logic [3:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;

    logic rd, wr, status_rd, rx_line;
    logic tx_push, tx_pop, flush_tx, tx_full, tx_empty;
    logic rx_pop, flush_rx, rx_full, rx_empty;
    logic tx_wr, tx_busy, rx_wr;
    logic rx_overrun, tx_overflow, ovr_evt, ovf_evt;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic [RX_DEPTH_LOG2:0] rx_count;
    logic [7:0] tx_head, tx_byte, rx_head, rx_data, status, rd_mux;
    tx_state_t state, state_nx;

    assign rd        = i_en && !i_wr;
    assign wr        = i_en && i_wr;
    assign status_rd = rd && (i_addr == ADDR_STATUS);
    assign rx_pop    = rd && (i_addr == ADDR_RX_DAT);
    assign tx_push   = wr && (i_addr == ADDR_TX_DAT);
    assign flush_tx  = wr && (i_addr == ADDR_CTRL) && i_data[CTRL_FLUSH_TX];
    assign flush_rx  = wr && (i_addr == ADDR_CTRL) && i_data[CTRL_FLUSH_RX];
    assign ovf_evt   = tx_push && tx_full && !tx_pop;
    assign ovr_evt   = rx_wr && rx_full && !rx_pop;

`ifdef UART_LOOPBACK_EN
    logic unused_rx;
    assign unused_rx = i_rx;
    assign rx_line   = o_tx;
`else
    assign rx_line = i_rx;
`endif

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(flush_tx),
        .i_push(tx_push), .i_data(i_data), .i_pop(tx_pop),
        .o_data(tx_head), .o_full(tx_full), .o_empty(tx_empty),
        .o_count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(flush_rx),
        .i_push(rx_wr), .i_data(rx_data), .i_pop(rx_pop),
        .o_data(rx_head), .o_full(rx_full), .o_empty(rx_empty),
        .o_count(rx_count)
    );

    serial_tx #(.CLKS_PER_BIT(CPB)) u_tx (
        .i_clk(i_clk), .i_wr(tx_wr), .i_data(tx_byte),
        .o_tx(o_tx), .o_busy(tx_busy)
    );

    serial_rx #(.CLKS_PER_BIT(CPB)) u_rx (
        .i_clk(i_clk), .i_rx(rx_line),
        .o_wr(rx_wr), .o_data(rx_data)
    );

    // A flush in the same cycle must not let the head escape to the line
    always_comb begin
        state_nx = state;
        tx_pop   = 1'b0;
        tx_wr    = 1'b0;
        unique case (state)
            TX_IDLE: begin
                if (!tx_empty && !tx_busy && !flush_tx) begin
                    tx_pop   = 1'b1;
                    state_nx = TX_LOAD;
                end
            end
            TX_LOAD: begin
                tx_wr    = 1'b1;
                state_nx = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: if (tx_busy) state_nx = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!tx_busy) state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= TX_IDLE;
        else       state <= state_nx;
        if (tx_pop) tx_byte <= tx_head;
    end

    always_comb begin
        status                 = '0;
        status[ST_RX_OVERRUN]  = rx_overrun;
        status[ST_TX_OVERFLOW] = tx_overflow;
        status[ST_TX_ACTIVE]   = (state != TX_IDLE);
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_EMPTY]    = tx_empty;
    end

    always_comb begin
        rd_mux = 8'h00;
        unique case (i_addr)
            ADDR_TX_RDY: rd_mux = tx_full ? 8'h00 : 8'hFF;
            ADDR_RX_RDY: rd_mux = rx_empty ? 8'h00 : 8'hFF;
            ADDR_RX_DAT: rd_mux = rx_empty ? 8'h00 : rx_head;
            ADDR_TX_CNT: rd_mux = 8'(tx_count);
            ADDR_RX_CNT: rd_mux = 8'(rx_count);
            ADDR_STATUS: rd_mux = status;
            default:     rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data      <= 8'h00;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (rd) o_data <= rd_mux;
            rx_overrun  <= ovr_evt || (rx_overrun && !status_rd);
            tx_overflow <= ovf_evt || (tx_overflow && !status_rd);
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: register reads and serial output are
// checked against a queue-based model of the register map.
module tb_uart_fifo;
    import uart_fifo_pkg::*;

    localparam int CPB   = 16;
    localparam int DL    = 2;
    localparam int DEPTH = 4;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_rx;
    logic       o_tx;
    logic       i_en = 1'b0;
    logic       i_wr = 1'b0;
    logic [3:0] i_addr = 4'd0;
    logic [7:0] i_data = 8'd0;
    logic [7:0] o_data;
    logic       lb = 1'b0;
    logic       rx_drv = 1'b1;
    logic       rd_d = 1'b0;

    assign i_rx = lb ? o_tx : rx_drv;
    always #5 i_clk = ~i_clk;

    uart_fifo #(
        .CLK_FREQ(16), .BAUD_RATE(1),
        .TX_DEPTH_LOG2(DL), .RX_DEPTH_LOG2(DL)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx), .o_tx(o_tx),
        .i_en(i_en), .i_wr(i_wr), .i_addr(i_addr),
        .i_data(i_data), .o_data(o_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [3:0] adr_q[$];
    logic [7:0] m_txf[$];
    logic [7:0] m_rx[$];
    logic [7:0] m_line[$];
    bit m_ovr = 0, m_ovf = 0, m_active = 0;

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic rx_model_push(logic [7:0] b);
        if (m_rx.size() < DEPTH) m_rx.push_back(b);
        else m_ovr = 1;
    endtask

    // transmitter takes the FIFO head while idle
    task automatic kick();
        if (m_txf.size() > 0) begin
            m_line.push_back(m_txf.pop_front());
            m_active = 1;
        end
    endtask

    task automatic wr(logic [3:0] a, logic [7:0] d);
        if (a == ADDR_TX_DAT) begin
            if (m_txf.size() < DEPTH) m_txf.push_back(d);
            else m_ovf = 1;
        end
        if (a == ADDR_CTRL) begin
            if (d[0]) m_rx.delete();
            if (d[1]) m_txf.delete();
        end
        i_en = 1; i_wr = 1; i_addr = a; i_data = d;
        @(posedge i_clk);
        #1;
        i_en = 0; i_wr = 0;
    endtask

    task automatic rd(logic [3:0] a);
        logic [7:0] e;
        e = 8'h00;
        case (a)
            ADDR_TX_RDY: e = (m_txf.size() < DEPTH) ? 8'hFF : 8'h00;
            ADDR_RX_RDY: e = (m_rx.size() != 0) ? 8'hFF : 8'h00;
            ADDR_RX_DAT: if (m_rx.size() != 0) e = m_rx.pop_front();
            ADDR_TX_CNT: e = 8'(m_txf.size());
            ADDR_RX_CNT: e = 8'(m_rx.size());
            ADDR_STATUS: begin
                e = {3'b000, m_txf.size() == 0, m_rx.size() == DEPTH,
                     m_active, m_ovf, m_ovr};
                m_ovf = 0;
                m_ovr = 0;
            end
            default: e = 8'h00;
        endcase
        exp_q.push_back(e);
        adr_q.push_back(a);
        i_en = 1; i_wr = 0; i_addr = a;
        @(posedge i_clk);
        #1;
        i_en = 0;
    endtask

    // back-to-back TX_DAT writes starting with an idle transmitter
    task automatic tx_burst(int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (i == 1) kick();
            wr(ADDR_TX_DAT, b);
        end
        if (n == 1) kick();
    endtask

    task automatic drain_model();
        while (m_txf.size() > 0) m_line.push_back(m_txf.pop_front());
    endtask

    task automatic send_serial(logic [7:0] b);
        rx_drv = 0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            cyc(CPB);
        end
        rx_drv = 1;
        cyc(2 * CPB);
        rx_model_push(b);
    endtask

    always @(posedge i_clk) rd_d <= i_en && !i_wr && !i_rst;

    always @(negedge i_clk) begin
        if (rd_d) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL read: got %02h with no expected value", o_data);
            end else begin
                check($sformatf("read addr %0d", adr_q.pop_front()),
                      o_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge o_tx);
            repeat (CPB / 2) @(negedge i_clk);
            if (o_tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge i_clk);
                    b[i] = o_tx;
                end
                repeat (CPB) @(negedge i_clk);
                if (m_line.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL serial: got %02h, none expected", b);
                end else begin
                    check("serial byte", b, m_line.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        bit found;

        cyc(2);
        check("reset o_data", o_data, 8'h00);
        i_rst = 0;
        cyc(1);

        // reset state, unmapped and write-only reads, ignored writes
        rd(ADDR_TX_RDY); rd(ADDR_RX_RDY); rd(ADDR_TX_CNT);
        rd(ADDR_RX_CNT); rd(ADDR_STATUS); rd(ADDR_TX_DAT);
        rd(ADDR_CTRL); rd(4'd9); rd(4'd15);
        wr(ADDR_TX_RDY, 8'h5A);
        wr(4'd12, 8'h33);
        rd(ADDR_TX_CNT); rd(ADDR_STATUS);

        // external loopback of three random bytes
        lb = 1;
        tx_burst(3);
        rd(ADDR_TX_CNT);
        drain_model();
        foreach (m_line[i]) rx_model_push(m_line[i]);
        cyc(700);
        m_active = 0;
        rd(ADDR_RX_CNT); rd(ADDR_RX_RDY);
        rd(ADDR_RX_DAT); rd(ADDR_RX_DAT); rd(ADDR_RX_DAT);
        rd(ADDR_RX_RDY); rd(ADDR_RX_DAT); rd(ADDR_STATUS);
        lb = 0;
        cyc(2);

        // TX overflow: one byte in flight plus a full FIFO
        tx_burst(6);
        rd(ADDR_TX_CNT); rd(ADDR_TX_RDY);
        rd(ADDR_STATUS); rd(ADDR_STATUS);
        drain_model();
        cyc(1000);
        m_active = 0;
        rd(ADDR_STATUS); rd(ADDR_TX_RDY);

        // RX overrun
        for (int i = 0; i < 5; i++) send_serial(8'($urandom));
        rd(ADDR_RX_CNT); rd(ADDR_STATUS); rd(ADDR_STATUS);

        // pop on a full RX FIFO in the same cycle as an arriving byte
        b = 8'($urandom);
        found = 0;
        fork
            send_serial(b);
            begin
                for (int k = 0; k < 400 && !found; k++) begin
                    @(posedge i_clk);
                    #1;
                    if (dut.rx_wr) found = 1;
                end
                if (found) rd(ADDR_RX_DAT);
                else check("rx_wr seen", 8'h00, 8'h01);
            end
        join
        rd(ADDR_RX_CNT); rd(ADDR_STATUS);
        rd(ADDR_RX_DAT); rd(ADDR_RX_DAT);
        rd(ADDR_RX_DAT); rd(ADDR_RX_DAT);
        rd(ADDR_RX_RDY);

        // RX flush
        send_serial(8'($urandom));
        send_serial(8'($urandom));
        rd(ADDR_RX_CNT);
        wr(ADDR_CTRL, 8'h01);
        rd(ADDR_RX_CNT); rd(ADDR_RX_RDY);

        // TX flush leaves the in-flight character alone
        tx_burst(3);
        wr(ADDR_CTRL, 8'h02);
        rd(ADDR_TX_CNT); rd(ADDR_STATUS);
        cyc(400);
        m_active = 0;
        rd(ADDR_STATUS);

        // reset mid-character with both FIFOs holding data
        send_serial(8'($urandom));
        tx_burst(3);
        cyc(40);
        rd(ADDR_TX_RDY);
        i_rst = 1;
        cyc(1);
        check("o_data in reset", o_data, 8'h00);
        i_rst = 0;
        m_txf.delete();
        m_rx.delete();
        m_ovr = 0;
        m_ovf = 0;
        m_active = 0;
        rd(ADDR_TX_CNT); rd(ADDR_RX_CNT); rd(ADDR_STATUS);
        cyc(300);

        check("serial left", 8'(m_line.size()), 8'd0);
        cyc(4);
        check("reads left", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
